// File: rtl/mca_pipe.sv
// mca_pipe: pipelined wide adder/subtractor with valid/ready flow control.
//
// The WIDTH-bit operation is split into STAGES limbs of L = ceil(WIDTH/STAGES) bits (the top limb
// may be narrower). Stage k adds limb k and registers the carry for stage k+1, so each stage holds
// only an L-bit adder. Operands and partial results travel down the pipe with their valid bit.
// Legal configurations need (STAGES-1)*L < WIDTH so that every stage owns at least one bit.
//
// Ports:
//   clk        clock, all state on the rising edge
//   rstn       asynchronous active-low reset
//   in_valid   operand x/y/sub valid         in_ready   operand accepted this cycle
//   sub        0: z = x + y, 1: z = x - y    x, y       operands
//   out_valid  z/cout valid                  out_ready  downstream accepts z/cout
//   z          result (mod 2^WIDTH)          cout       add: carry out, sub: 1 = no borrow
module mca_pipe #(
  parameter int unsigned WIDTH  = 272,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             cout
);

  localparam int unsigned L = (WIDTH + STAGES - 1) / STAGES;

  // Whole-pipe stall: every stage advances together or holds together.
  logic en;

  // Stage registers; entry STAGES-1 is the output stage.
  logic             v_q  [STAGES];
  logic [WIDTH-1:0] x_q  [STAGES];
  logic [WIDTH-1:0] yp_q [STAGES];  // y already conditioned (~y for subtract)
  logic [WIDTH-1:0] z_q  [STAGES];  // result limbs produced so far
  logic             c_q  [STAGES];  // carry into the next limb

  // Per-stage inputs and next-state values.
  logic             v_in  [STAGES];
  logic [WIDTH-1:0] x_in  [STAGES];
  logic [WIDTH-1:0] yp_in [STAGES];
  logic [WIDTH-1:0] z_in  [STAGES];
  logic             c_in  [STAGES];
  logic [WIDTH-1:0] z_d   [STAGES];
  logic             c_d   [STAGES];

  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign out_valid = v_q[STAGES-1];
  assign z         = z_q[STAGES-1];
  assign cout      = c_q[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned Lo = k * L;
    localparam int unsigned Wk = ((WIDTH - Lo) < L) ? (WIDTH - Lo) : L;
    localparam logic [WIDTH-1:0] Mask = ({WIDTH{1'b1}} >> (WIDTH - Wk)) << Lo;

    logic [Wk:0] sum;

    if (k == 0) begin : g_head
      // Subtract is x + ~y + 1: the +1 enters as the carry into limb 0.
      assign v_in[k]  = in_valid;
      assign x_in[k]  = x;
      assign yp_in[k] = sub ? ~y : y;
      assign z_in[k]  = '0;
      assign c_in[k]  = sub;
    end else begin : g_body
      assign v_in[k]  = v_q[k-1];
      assign x_in[k]  = x_q[k-1];
      assign yp_in[k] = yp_q[k-1];
      assign z_in[k]  = z_q[k-1];
      assign c_in[k]  = c_q[k-1];
    end

    assign sum    = {1'b0, x_in[k][Lo +: Wk]} + {1'b0, yp_in[k][Lo +: Wk]}
                  + {{Wk{1'b0}}, c_in[k]};
    assign z_d[k] = (z_in[k] & ~Mask) | (WIDTH'(sum[Wk-1:0]) << Lo);
    assign c_d[k] = sum[Wk];
  end

  // Data registers load only with a valid op, so z/cout hold their last value across bubbles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k]  <= 1'b0;
        x_q[k]  <= '0;
        yp_q[k] <= '0;
        z_q[k]  <= '0;
        c_q[k]  <= 1'b0;
      end
    end else if (en) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= v_in[k];
        if (v_in[k]) begin
          x_q[k]  <= x_in[k];
          yp_q[k] <= yp_in[k];
          z_q[k]  <= z_d[k];
          c_q[k]  <= c_d[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_mca_pipe.sv
// tb_mca_pipe: directed and randomised-traffic bench for mca_pipe (WIDTH=272, STAGES=2 and 4).
module tb_mca_pipe;

  localparam int unsigned W  = 272;
  localparam int unsigned WC = W + 1;

  logic         clk  = 1'b0;
  logic         rstn = 1'b1;
  logic         in_valid  = 1'b0;
  logic         in_valid4 = 1'b0;
  logic         out_ready  = 1'b1;
  logic         out_ready4 = 1'b1;
  logic         sub = 1'b0;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic         in_ready, out_valid, cout;
  logic         in_ready4, out_valid4, cout4;
  logic [W-1:0] z, z4;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  mca_pipe #(.WIDTH(W), .STAGES(2)) u_dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sub       (sub),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .cout      (cout)
  );

  mca_pipe #(.WIDTH(W), .STAGES(4)) u_dut4 (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .sub       (sub),
    .x         (x),
    .y         (y),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .z         (z4),
    .cout      (cout4)
  );

  task automatic check_eq(input string tag, input logic [W:0] got, input logic [W:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Random operand, with all-zeros and all-ones mixed in to exercise full carry chains.
  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] r;
    int unsigned  m;
    r = '0;
    m = $urandom_range(0, 7);
    if (m == 0) return '0;
    if (m == 1) return '1;
    for (int i = 0; i < 9; i++) r = (r << 32) | W'($urandom());
    return r;
  endfunction

  // Reference: {cout, z}; subtract reports cout = 1 when there is no borrow.
  function automatic logic [W:0] model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    if (s) return {(a >= b) ? 1'b1 : 1'b0, a - b};
    return {1'b0, a} + {1'b0, b};
  endfunction

  task automatic run_dir(input string tag, input logic s, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W:0] exp);
    int cyc;
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1; sub = s; x = a; y = b;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, " latency"}, WC'(cyc), WC'(2));
    check_eq({tag, " result"}, {cout, z}, exp);
  endtask

  task automatic run_dir4(input string tag, input logic s, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W:0] exp);
    int cyc;
    @(negedge clk);
    in_valid4 = 1'b1; sub = s; x = a; y = b;
    @(negedge clk);
    in_valid4 = 1'b0;
    cyc = 1;
    while (!out_valid4 && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, " latency"}, WC'(cyc), WC'(4));
    check_eq({tag, " result"}, {cout4, z4}, exp);
  endtask

  // Drives n ops with pv% in_valid and pr% out_ready; scoreboards every output in order.
  task automatic run_stream(input string tag, input int n, input int pv, input int pr,
                            output int cycles);
    logic [W:0] q[$];
    int sent;
    int got;
    sent   = 0;
    got    = 0;
    cycles = 0;
    while ((sent < n || got < n) && cycles < 20 * n + 50) begin
      @(negedge clk);
      in_valid  = (sent < n) && ($urandom_range(0, 99) < pv);
      out_ready = ($urandom_range(0, 99) < pr);
      sub       = 1'($urandom_range(0, 1));
      x         = rand_word();
      y         = rand_word();
      #1;
      check_eq({tag, " in_ready"}, WC'(in_ready), WC'(!out_valid || out_ready));
      if (out_valid) begin
        if (q.size() > 0) check_eq({tag, " data"}, {cout, z}, q[0]);
        else              check_eq({tag, " spurious"}, WC'(out_valid), WC'(0));
        if (out_ready) begin
          got++;
          if (q.size() > 0) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(sub, x, y));
        sent++;
      end
      cycles++;
    end
    in_valid = 1'b0;
    check_eq({tag, " count"}, WC'(got), WC'(n));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [W-1:0] ones;
    logic [W-1:0] lo_ones;
    logic [W-1:0] b136;
    ones    = '1;
    lo_ones = (W'(1) << 136) - W'(1);
    b136    = W'(1) << 136;

    // Reset state.
    #2 rstn = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst out_valid", WC'(out_valid), WC'(0));
    check_eq("rst z/cout", {cout, z}, '0);
    check_eq("rst in_ready", WC'(in_ready), WC'(1));
    check_eq("rst out_valid4", WC'(out_valid4), WC'(0));
    rstn = 1'b1;

    // Directed vectors.
    run_dir("add max+1", 1'b0, ones, W'(1), {1'b1, {W{1'b0}}});
    run_dir("sub 5-7", 1'b1, W'(5), W'(7), {1'b0, ones - W'(1)});
    run_dir("sub 7-5", 1'b1, W'(7), W'(5), {1'b0, W'(2)} | {1'b1, {W{1'b0}}});
    run_dir("sub x-x", 1'b1, W'(12345), W'(12345), {1'b1, {W{1'b0}}});
    run_dir("add limb carry", 1'b0, lo_ones, W'(1), {1'b0, b136});
    run_dir("add max+max", 1'b0, ones, ones, {1'b1, ones - W'(1)});
    run_dir("add 0+0", 1'b0, W'(0), W'(0), '0);
    run_dir4("s4 limb carry", 1'b0, lo_ones, W'(1), {1'b0, b136});
    run_dir4("s4 max+1", 1'b0, ones, W'(1), {1'b1, {W{1'b0}}});
    run_dir4("s4 sub 5-7", 1'b1, W'(5), W'(7), {1'b0, ones - W'(1)});

    // Back-to-back at full throughput: n ops drain in n + STAGES cycles.
    run_stream("b2b", 100, 100, 100, cyc);
    check_eq("b2b cycles", WC'(cyc), WC'(102));

    // Random valid/ready traffic.
    run_stream("rnd", 150, 70, 50, cyc);

    // Reset with two ops in flight.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; sub = 1'b0; x = W'(5); y = W'(6);
    @(negedge clk);
    x = W'(7); y = W'(8);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check_eq("mid pre valid", WC'(out_valid), WC'(1));
    check_eq("mid pre data", {cout, z}, WC'(11));
    rstn = 1'b0;
    #1;
    check_eq("mid rst valid", WC'(out_valid), WC'(0));
    check_eq("mid rst z/cout", {cout, z}, '0);
    check_eq("mid rst in_ready", WC'(in_ready), WC'(1));
    @(negedge clk);
    rstn = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("post rst stale", WC'(out_valid), WC'(0));
    end
    run_dir("post rst add", 1'b0, W'(100), W'(23), WC'(123));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
